// File: rtl/matmul_pkg.sv
// ---------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the sequential matrix multiplier:
//   state_t  - 3-bit controller state encoding
//   MODE_*   - job mode encodings (overwrite Z=A*B, accumulate Z=C+A*B)
//   idx_w()  - index width helper, max(1, clog2(x))
// ---------------------------------------------------------------------------
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BIAS  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic MODE_OVR = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  // A dimension of 1 still needs a 1-bit index port.
  function automatic int idx_w(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit
// Registered accumulator with a SIGNED-selectable DATA_W x DATA_W multiply.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (acc -> 0)
//   i_clear      - acc <= 0
//   i_load       - acc <= i_load_val
//   i_acc_en     - acc <= acc + i_a*i_b
//   i_load_val   - ACC_W preload value (bias element)
//   i_a, i_b     - operands
//   o_sum        - acc + i_a*i_b (combinational, wraps modulo 2^ACC_W)
// Priority: clear > load > accumulate.
// ---------------------------------------------------------------------------
module mac_unit #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2*DATA_W + 3,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_acc_en,
  input  logic [ACC_W-1:0]  i_load_val,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_sum
);

  logic [ACC_W-1:0]    r_acc;
  logic                w_sa;
  logic                w_sb;
  logic                w_psign;
  logic [2*DATA_W-1:0] w_a_ext;
  logic [2*DATA_W-1:0] w_b_ext;
  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_prod_ext;

  // Extending both operands to 2*DATA_W and keeping the low 2*DATA_W bits of
  // the product yields the exact signed or unsigned product either way.
  assign w_sa       = (SIGNED != 0) & i_a[DATA_W-1];
  assign w_sb       = (SIGNED != 0) & i_b[DATA_W-1];
  assign w_a_ext    = {{DATA_W{w_sa}}, i_a};
  assign w_b_ext    = {{DATA_W{w_sb}}, i_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_psign    = (SIGNED != 0) & w_prod[2*DATA_W-1];
  assign w_prod_ext = {{(ACC_W-2*DATA_W){w_psign}}, w_prod};
  assign o_sum      = r_acc + w_prod_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_load_val;
    end else if (i_acc_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/seq_matmul_mac.sv
// ---------------------------------------------------------------------------
// seq_matmul_mac
// Sequential integer matrix multiplier: Z = A*B or Z = C + A*B, one MAC per
// cycle, operands from 1-cycle-latency synchronous-read ports, results
// streamed row-major.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start, mode_acc          - job request (sampled in IDLE only), mode
//   busy, done               - not-IDLE flag, 1-cycle completion pulse
//   a_rd/a_row/a_col/a_in    - A read port (data the cycle after a_rd)
//   b_rd/b_row/b_col/b_in    - B read port
//   c_rd/c_row/c_col/c_in    - C (bias) read port
//   z_data/z_row/z_col       - result element and its position
//   z_valid/z_ready          - result handshake
//   dbg_state                - current controller state
// Handshake: an element transfers on a rising edge where z_valid and z_ready
// are both high. Once z_valid rises, z_data/z_row/z_col hold until that
// transfer; z_valid never depends on z_ready.
// ---------------------------------------------------------------------------
module seq_matmul_mac
  import matmul_pkg::*;
#(
  parameter int M      = 4,
  parameter int K      = 4,
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2*DATA_W + $clog2(K) + 1,
  parameter int SIGNED = 1,
  localparam int MW    = idx_w(M),
  localparam int KW    = idx_w(K),
  localparam int NW    = idx_w(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_acc,
  output logic              busy,
  output logic              done,
  output logic              a_rd,
  output logic [MW-1:0]     a_row,
  output logic [KW-1:0]     a_col,
  input  logic [DATA_W-1:0] a_in,
  output logic              b_rd,
  output logic [KW-1:0]     b_row,
  output logic [NW-1:0]     b_col,
  input  logic [DATA_W-1:0] b_in,
  output logic              c_rd,
  output logic [MW-1:0]     c_row,
  output logic [NW-1:0]     c_col,
  input  logic [ACC_W-1:0]  c_in,
  output logic [ACC_W-1:0]  z_data,
  output logic [MW-1:0]     z_row,
  output logic [NW-1:0]     z_col,
  output logic              z_valid,
  input  logic              z_ready,
  output logic [2:0]        dbg_state
);

  localparam logic [MW-1:0] I_LAST = MW'(M-1);
  localparam logic [KW-1:0] K_LAST = KW'(K-1);
  localparam logic [NW-1:0] J_LAST = NW'(N-1);

  state_t           r_state;
  state_t           w_next;
  logic             r_mode;
  logic [MW-1:0]    r_i;
  logic [KW-1:0]    r_k;
  logic [NW-1:0]    r_j;
  logic [ACC_W-1:0] r_z_data;
  logic [ACC_W-1:0] w_sum;
  logic             w_k_first;
  logic             w_k_last;
  logic             w_j_last;
  logic             w_last_elem;
  logic             w_first_mac;
  logic             w_mac_load;
  logic             w_mac_clear;
  logic             w_mac_acc;

  assign w_k_first   = (r_k == '0);
  assign w_k_last    = (r_k == K_LAST);
  assign w_j_last    = (r_j == J_LAST);
  assign w_last_elem = (r_i == I_LAST) && w_j_last;

  // The k=0 RUN edge starts a fresh element: the bias (fetched in BIAS)
  // or zero. Later RUN edges and the DRAIN edge each add the product of
  // the operands issued one cycle earlier.
  assign w_first_mac = (r_state == ST_RUN) && w_k_first;
  assign w_mac_load  = w_first_mac && (r_mode == MODE_ACC);
  assign w_mac_clear = w_first_mac && (r_mode == MODE_OVR);
  assign w_mac_acc   = ((r_state == ST_RUN) && !w_k_first) || (r_state == ST_DRAIN);

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_mac_clear),
    .i_load     (w_mac_load),
    .i_acc_en   (w_mac_acc),
    .i_load_val (c_in),
    .i_a        (a_in),
    .i_b        (b_in),
    .o_sum      (w_sum)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = (mode_acc == MODE_ACC) ? ST_BIAS : ST_RUN;
      ST_BIAS:  w_next = ST_RUN;
      ST_RUN:   if (w_k_last) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_OUT;
      ST_OUT: begin
        if (z_ready) begin
          if (w_last_elem)              w_next = ST_DONE;
          else if (r_mode == MODE_ACC)  w_next = ST_BIAS;
          else                          w_next = ST_RUN;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Counters, latched mode and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= MODE_OVR;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_z_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode <= mode_acc;
            r_i    <= '0;
            r_j    <= '0;
            r_k    <= '0;
          end
        end
        ST_RUN:   r_k <= w_k_last ? '0 : r_k + KW'(1);
        // w_sum already includes the final product on this edge.
        ST_DRAIN: r_z_data <= w_sum;
        ST_OUT: begin
          if (z_ready && !w_last_elem) begin
            if (w_j_last) begin
              r_j <= '0;
              r_i <= r_i + MW'(1);
            end else begin
              r_j <= r_j + NW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy    = (r_state != ST_IDLE);
    done    = (r_state == ST_DONE);
    a_rd    = (r_state == ST_RUN);
    b_rd    = (r_state == ST_RUN);
    c_rd    = (r_state == ST_BIAS);
    z_valid = (r_state == ST_OUT);
  end

  assign a_row     = r_i;
  assign a_col     = r_k;
  assign b_row     = r_k;
  assign b_col     = r_j;
  assign c_row     = r_i;
  assign c_col     = r_j;
  assign z_row     = r_i;
  assign z_col     = r_j;
  assign z_data    = r_z_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_matmul_mac.sv
// ---------------------------------------------------------------------------
// tb_seq_matmul_mac
// Four instances cover the shapes of interest; they share one set of operand
// matrices and one expected-result queue and run one at a time.
//   dut0: 2x2x2 signed 16-bit   dut1: M2 K3 N1 signed
//   dut2: M3 K1 N3 signed       dut3: M1 K3 N1 unsigned 4-bit
// Expected entries pack {row[7:0], col[7:0], data[47:0]}.
// ---------------------------------------------------------------------------
module tb_seq_matmul_mac;

  localparam int ACC0 = 34;
  localparam int ACC1 = 35;
  localparam int ACC2 = 33;
  localparam int ACC3 = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] start_v;
  logic [3:0] mode_v;
  wire  [3:0] busy_v;
  wire  [3:0] done_v;
  logic       zr0;
  logic       zr_hi;

  int a_m [3][3];
  int b_m [3][3];
  int c_m [3][3];

  logic [63:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int done_cnt [4];
  int crd_cnt;

  // ---------------- dut0 ----------------
  logic a_rd0, b_rd0, c_rd0, z_valid0;
  logic [0:0] a_row0, a_col0, b_row0, b_col0, c_row0, c_col0, z_row0, z_col0;
  logic [15:0] a_in0, b_in0;
  logic [ACC0-1:0] c_in0, z_data0;
  logic [2:0] dbg0;

  seq_matmul_mac #(.M(2), .K(2), .N(2), .DATA_W(16), .SIGNED(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .mode_acc(mode_v[0]),
    .busy(busy_v[0]), .done(done_v[0]),
    .a_rd(a_rd0), .a_row(a_row0), .a_col(a_col0), .a_in(a_in0),
    .b_rd(b_rd0), .b_row(b_row0), .b_col(b_col0), .b_in(b_in0),
    .c_rd(c_rd0), .c_row(c_row0), .c_col(c_col0), .c_in(c_in0),
    .z_data(z_data0), .z_row(z_row0), .z_col(z_col0),
    .z_valid(z_valid0), .z_ready(zr0), .dbg_state(dbg0));

  // ---------------- dut1 ----------------
  logic a_rd1, b_rd1, c_rd1, z_valid1;
  logic [0:0] a_row1, b_col1, c_row1, c_col1, z_row1, z_col1;
  logic [1:0] a_col1, b_row1;
  logic [15:0] a_in1, b_in1;
  logic [ACC1-1:0] c_in1, z_data1;
  logic [2:0] dbg1;

  seq_matmul_mac #(.M(2), .K(3), .N(1), .DATA_W(16), .SIGNED(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .mode_acc(mode_v[1]),
    .busy(busy_v[1]), .done(done_v[1]),
    .a_rd(a_rd1), .a_row(a_row1), .a_col(a_col1), .a_in(a_in1),
    .b_rd(b_rd1), .b_row(b_row1), .b_col(b_col1), .b_in(b_in1),
    .c_rd(c_rd1), .c_row(c_row1), .c_col(c_col1), .c_in(c_in1),
    .z_data(z_data1), .z_row(z_row1), .z_col(z_col1),
    .z_valid(z_valid1), .z_ready(zr_hi), .dbg_state(dbg1));

  // ---------------- dut2 ----------------
  logic a_rd2, b_rd2, c_rd2, z_valid2;
  logic [1:0] a_row2, b_col2, c_row2, c_col2, z_row2, z_col2;
  logic [0:0] a_col2, b_row2;
  logic [15:0] a_in2, b_in2;
  logic [ACC2-1:0] c_in2, z_data2;
  logic [2:0] dbg2;

  seq_matmul_mac #(.M(3), .K(1), .N(3), .DATA_W(16), .SIGNED(1)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .mode_acc(mode_v[2]),
    .busy(busy_v[2]), .done(done_v[2]),
    .a_rd(a_rd2), .a_row(a_row2), .a_col(a_col2), .a_in(a_in2),
    .b_rd(b_rd2), .b_row(b_row2), .b_col(b_col2), .b_in(b_in2),
    .c_rd(c_rd2), .c_row(c_row2), .c_col(c_col2), .c_in(c_in2),
    .z_data(z_data2), .z_row(z_row2), .z_col(z_col2),
    .z_valid(z_valid2), .z_ready(zr_hi), .dbg_state(dbg2));

  // ---------------- dut3 ----------------
  logic a_rd3, b_rd3, c_rd3, z_valid3;
  logic [0:0] a_row3, b_col3, c_row3, c_col3, z_row3, z_col3;
  logic [1:0] a_col3, b_row3;
  logic [3:0] a_in3, b_in3;
  logic [ACC3-1:0] c_in3, z_data3;
  logic [2:0] dbg3;

  seq_matmul_mac #(.M(1), .K(3), .N(1), .DATA_W(4), .SIGNED(0)) dut3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .mode_acc(mode_v[3]),
    .busy(busy_v[3]), .done(done_v[3]),
    .a_rd(a_rd3), .a_row(a_row3), .a_col(a_col3), .a_in(a_in3),
    .b_rd(b_rd3), .b_row(b_row3), .b_col(b_col3), .b_in(b_in3),
    .c_rd(c_rd3), .c_row(c_row3), .c_col(c_col3), .c_in(c_in3),
    .z_data(z_data3), .z_row(z_row3), .z_col(z_col3),
    .z_valid(z_valid3), .z_ready(zr_hi), .dbg_state(dbg3));

  // ---------------- operand memories (1-cycle read latency) ----------------
  always_ff @(posedge clk) begin
    if (a_rd0) a_in0 <= 16'(a_m[int'(a_row0)][int'(a_col0)]);
    if (b_rd0) b_in0 <= 16'(b_m[int'(b_row0)][int'(b_col0)]);
    if (c_rd0) c_in0 <= ACC0'(c_m[int'(c_row0)][int'(c_col0)]);
    if (a_rd1) a_in1 <= 16'(a_m[int'(a_row1)][int'(a_col1)]);
    if (b_rd1) b_in1 <= 16'(b_m[int'(b_row1)][int'(b_col1)]);
    if (c_rd1) c_in1 <= ACC1'(c_m[int'(c_row1)][int'(c_col1)]);
    if (a_rd2) a_in2 <= 16'(a_m[int'(a_row2)][int'(a_col2)]);
    if (b_rd2) b_in2 <= 16'(b_m[int'(b_row2)][int'(b_col2)]);
    if (c_rd2) c_in2 <= ACC2'(c_m[int'(c_row2)][int'(c_col2)]);
    if (a_rd3) a_in3 <= 4'(a_m[int'(a_row3)][int'(a_col3)]);
    if (b_rd3) b_in3 <= 4'(b_m[int'(b_row3)][int'(b_col3)]);
    if (c_rd3) c_in3 <= ACC3'(c_m[int'(c_row3)][int'(c_col3)]);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pop_cmp(input string tag, input logic [63:0] got);
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 64'(exp_q.size()), 64'd1);
    end else begin
      check(tag, got, exp_q.pop_front());
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (z_valid0 && zr0)   pop_cmp("z0", {8'(z_row0), 8'(z_col0), 48'(z_data0)});
      if (z_valid1 && zr_hi) pop_cmp("z1", {8'(z_row1), 8'(z_col1), 48'(z_data1)});
      if (z_valid2 && zr_hi) pop_cmp("z2", {8'(z_row2), 8'(z_col2), 48'(z_data2)});
      if (z_valid3 && zr_hi) pop_cmp("z3", {8'(z_row3), 8'(z_col3), 48'(z_data3)});
      for (int d = 0; d < 4; d++) if (done_v[d]) done_cnt[d]++;
      if (c_rd0) crd_cnt++;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] exp_elem(int i, int j, int k, bit acc_mode, int accw);
    longint acc;
    logic [63:0] vv;
    acc = acc_mode ? longint'(c_m[i][j]) : 64'sd0;
    for (int kk = 0; kk < k; kk++) acc += longint'(a_m[i][kk]) * longint'(b_m[kk][j]);
    vv = 64'(acc) & ((64'd1 << accw) - 64'd1);
    return {8'(i), 8'(j), vv[47:0]};
  endfunction

  task automatic push_model(input int m, input int k, input int n, input bit acc_mode, input int accw);
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        exp_q.push_back(exp_elem(i, j, k, acc_mode, accw));
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mats();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        a_m[i][j] = 0; b_m[i][j] = 0; c_m[i][j] = 0;
      end
  endtask

  task automatic rand_mats(input bit with_c);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        a_m[i][j] = int'($urandom_range(2000)) - 1000;
        b_m[i][j] = int'($urandom_range(2000)) - 1000;
        c_m[i][j] = with_c ? int'($urandom_range(200000)) - 100000 : 0;
      end
  endtask

  // Leaves the caller #1 into the first cycle after start was sampled.
  task automatic start_job(input int d, input bit m);
    @(posedge clk); #1;
    start_v[d] = 1'b1;
    mode_v[d]  = m;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    mode_v[d]  = 1'b0;
  endtask

  // n = index of the cycle (1 = first cycle after start) showing done.
  task automatic wait_done(input int d, input int limit, output int n);
    n = 1;
    while (!done_v[d] && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_zv0(input int limit);
    int n;
    n = 0;
    while (!z_valid0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_zv0", 64'(z_valid0), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int saved;
    logic [63:0] e;
    rst = 1'b1; start_v = '0; mode_v = '0; zr0 = 1'b1; zr_hi = 1'b1; crd_cnt = 0;
    for (int d = 0; d < 4; d++) done_cnt[d] = 0;
    clear_mats();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy_v), 64'd0);
    check("rst_done", 64'(done_v), 64'd0);
    check("rst_zvalid", 64'({z_valid0, z_valid1, z_valid2, z_valid3}), 64'd0);
    check("rst_rd", 64'({a_rd0, b_rd0, c_rd0}), 64'd0);
    check("rst_zdata", 64'(z_data0), 64'd0);
    check("rst_idx", 64'({a_row0, a_col0, b_row0, b_col0, c_row0, c_col0, z_row0, z_col0}), 64'd0);
    check("rst_state", 64'(dbg0), 64'd0);
    rst = 1'b0;

    // T1: overwrite, known 2x2 product; start during DONE must be ignored
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
    b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
    push_model(2, 2, 2, 1'b0, ACC0);
    start_job(0, 1'b0);
    wait_done(0, 400, n);
    check("t1_cycles", 64'(n), 64'd17);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check("t1_done_pulse", 64'(done_v[0]), 64'd0);
    @(posedge clk); #1;
    check("t1_start_in_done", 64'(busy_v[0]), 64'd0);
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);
    check("t1_done_cnt", 64'(done_cnt[0]), 64'd1);

    // T2: accumulate with C=[[100,0],[0,-1]]
    c_m[0][0] = 100; c_m[0][1] = 0; c_m[1][0] = 0; c_m[1][1] = -1;
    crd_cnt = 0;
    push_model(2, 2, 2, 1'b1, ACC0);
    start_job(0, 1'b1);
    wait_done(0, 400, n);
    check("t2_cycles", 64'(n), 64'd21);
    check("t2_crd_cnt", 64'(crd_cnt), 64'd4);
    @(posedge clk); #1;

    // T3: random operands, z_ready low for 5 cycles on the second element
    rand_mats(1'b0);
    push_model(2, 2, 2, 1'b0, ACC0);
    zr0 = 1'b0;
    start_job(0, 1'b0);
    wait_zv0(50);
    zr0 = 1'b1;
    @(posedge clk); #1;
    zr0 = 1'b0;
    wait_zv0(50);
    e = exp_elem(0, 1, 2, 1'b0, ACC0);
    for (int c = 0; c < 5; c++) begin
      check("t3_stall_z", {8'(z_row0), 8'(z_col0), 48'(z_data0)}, e);
      check("t3_stall_rd", 64'({a_rd0, b_rd0, c_rd0, z_valid0}), 64'd1);
      @(posedge clk); #1;
    end
    zr0 = 1'b1;
    wait_done(0, 400, n);
    check("t3_done", 64'(done_v[0]), 64'd1);
    @(posedge clk); #1;
    check("t3_q_empty", 64'(exp_q.size()), 64'd0);

    // T4: reset during RUN of the third element (1,0), then a fresh job
    rand_mats(1'b1);
    push_model(2, 2, 2, 1'b0, ACC0);
    start_job(0, 1'b0);
    n = 0;
    while (!(a_rd0 && a_row0 == 1'b1 && b_col0 == 1'b0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4_reach_run", 64'(a_rd0 && a_row0 == 1'b1), 64'd1);
    saved = done_cnt[0];
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("t4_busy", 64'(busy_v[0]), 64'd0);
    check("t4_outs", 64'({z_valid0, a_rd0, b_rd0, c_rd0, done_v[0]}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t4_no_done", 64'(done_cnt[0]), 64'(saved));
    push_model(2, 2, 2, 1'b1, ACC0);
    start_job(0, 1'b1);
    wait_done(0, 400, n);
    check("t4_cycles", 64'(n), 64'd21);
    @(posedge clk); #1;
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // T5: signed rectangular, M=2 K=3 N=1 -> -6, 15
    clear_mats();
    a_m[0][0] = -1; a_m[0][1] = -2; a_m[0][2] = -3;
    a_m[1][0] = 4;  a_m[1][1] = 5;  a_m[1][2] = 6;
    b_m[0][0] = 1;  b_m[1][0] = 1;  b_m[2][0] = 1;
    push_model(2, 3, 1, 1'b0, ACC1);
    start_job(1, 1'b0);
    wait_done(1, 400, n);
    check("t5_cycles", 64'(n), 64'd11);
    @(posedge clk); #1;

    // T6: unsigned 4-bit, all 15, K=3 -> 675
    clear_mats();
    for (int k = 0; k < 3; k++) begin a_m[0][k] = 15; b_m[k][0] = 15; end
    push_model(1, 3, 1, 1'b0, ACC3);
    start_job(3, 1'b0);
    wait_done(3, 400, n);
    check("t6_cycles", 64'(n), 64'd6);
    @(posedge clk); #1;

    // T7: K=1, 3x3 of 2*(-3) = -6, then accumulate with random C
    clear_mats();
    for (int i = 0; i < 3; i++) begin a_m[i][0] = 2; b_m[0][i] = -3; end
    push_model(3, 1, 3, 1'b0, ACC2);
    start_job(2, 1'b0);
    wait_done(2, 400, n);
    check("t7_cycles", 64'(n), 64'd28);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) c_m[i][j] = int'($urandom_range(2000)) - 1000;
    push_model(3, 1, 3, 1'b1, ACC2);
    start_job(2, 1'b1);
    wait_done(2, 400, n);
    check("t7_acc_cycles", 64'(n), 64'd37);
    @(posedge clk); #1;

    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    check("done_cnt0", 64'(done_cnt[0]), 64'd4);
    check("done_cnt1", 64'(done_cnt[1]), 64'd1);
    check("done_cnt2", 64'(done_cnt[2]), 64'd2);
    check("done_cnt3", 64'(done_cnt[3]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/seq_matmul_mac.md
# seq_matmul_mac

Parametrised sequential integer matrix multiplier computing Z = A·B (overwrite mode) or Z = C + A·B (accumulate mode). A is M×K, B is K×N and C/Z are M×N, all rectangular. Operands are fetched through synchronous-read memory ports with one-cycle read latency. One multiply-accumulate is performed per cycle, and each finished element is streamed out row-major over a valid/ready handshake. The block sits between operand RAMs and a result sink, replacing the square, float-only, one-handshake-per-operand multiplier.

## Interface
Parameters:
- M, 4: rows of A and Z (≥1).
- K, 4: columns of A, rows of B (≥1).
- N, 4: columns of B and Z (≥1).
- DATA_W, 16: width of an A or B element.
- ACC_W, 2*DATA_W+$clog2(K)+1: width of the accumulator, c_in and z_data.
- SIGNED, 1: 1 selects two's-complement operands; 0 selects unsigned.

Ports (MW, KW, NW are max(1,$clog2(M|K|N))):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- mode_acc  in  1  sampled with start: 1 selects Z=C+A·B.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last element is accepted.
- a_rd  out  1  A read strobe.
- a_row  out  MW  A row index.
- a_col  out  KW  A column index.
- a_in  in  DATA_W  A data, valid the cycle after a_rd.
- b_rd  out  1  B read strobe.
- b_row  out  KW  B row index.
- b_col  out  NW  B column index.
- b_in  in  DATA_W  B data, valid the cycle after b_rd.
- c_rd  out  1  C read strobe.
- c_row  out  MW  C row index.
- c_col  out  NW  C column index.
- c_in  in  ACC_W  C data, valid the cycle after c_rd.
- z_data  out  ACC_W  result element.
- z_row  out  MW  result row index.
- z_col  out  NW  result column index.
- z_valid  out  1  result element valid.
- z_ready  in  1  sink accepts the result element.

## Operation
- States: IDLE, BIAS, RUN, DRAIN, OUT, DONE.
- IDLE & start → BIAS if mode_acc, else RUN. Latch mode; clear i, j, k.
- BIAS (1 cycle): c_rd=1, c_row=i, c_col=j. → RUN.
- RUN (K cycles, k=0..K-1):
  - a_rd=b_rd=1, a_row=i, a_col=k, b_row=k, b_col=j.
  - On the k=0 edge: acc ← sign- or zero-extended c_in in accumulate mode, else 0.
  - On edges k≥1: acc ← acc + a_in·b_in, using data from the previous issue.
  - After k=K-1 → DRAIN.
- DRAIN (1 cycle): acc ← acc + a_in·b_in for the last product. → OUT.
- OUT: z_valid=1, z_data=acc, z_row=i, z_col=j, all held stable until z_ready.
- On the OUT handshake:
  - If the last element was just accepted (i=M-1, j=N-1) → DONE.
  - Otherwise advance j; j wraps at N-1 and increments i. → BIAS/RUN per the latched mode.
- DONE (1 cycle): done=1. → IDLE.
- Arithmetic:
  - Each product is full 2·DATA_W, extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; there is no saturation.
  - SIGNED selects signed or unsigned multiply and extension.
- start and mode_acc are ignored while busy.
- Read strobes are low outside BIAS/RUN. Index outputs are don't-care while their strobe is low.

## Timing
- Reset values: busy=0, done=0, z_valid=0, a_rd=b_rd=c_rd=0, z_data=0, all indices 0, state IDLE.
- rst mid-job:
  - Aborts the job on the next edge; a held z_valid drops.
  - No done pulse is generated for the aborted job.
- Cycles per element with z_ready held high:
  - Overwrite mode: K+2 (RUN K, DRAIN 1, OUT 1).
  - Accumulate mode: K+3.
- Whole job, z_ready high: M·N·(K+2 [+1]) + 1 cycles from the cycle after start to the done pulse.
- z_valid is asserted no earlier than the cycle after DRAIN. A result never changes while z_valid=1 and z_ready=0.
- K=1: RUN lasts 1 cycle, and only the DRAIN edge adds a product.
- A start arriving in the DONE cycle is ignored; start is accepted from IDLE only.

## Structure
- Shared package matmul_pkg holds:
  - the state enum (3-bit),
  - an index-width helper function max(1,$clog2(x)),
  - the mode encodings.
- The sub-module mac_unit holds:
  - the registered accumulator, with load/clear/accumulate controls,
  - the SIGNED-selectable multiply and extension.
- The top level holds the FSM, the i/j/k counters and the output register.

## Test plan
- M=K=N=2, overwrite, A=[[1,2],[3,4]], B=[[5,6],[7,8]], z_ready=1 → z stream 19,22,43,50 at (0,0),(0,1),(1,0),(1,1); done once; 17 cycles from the cycle after start to done.
- Same A and B, accumulate mode, C=[[100,0],[0,−1]] → 119,22,43,49; c_rd asserted once per element.
- M=2, K=3, N=1, SIGNED=1, A=[[−1,−2,−3],[4,5,6]], B=[1,1,1] → −6, 15. SIGNED=0 with DATA_W=4 and all operands 15, K=3 → 675.
- z_ready low for 5 cycles on the second element → z_data/z_row/z_col stable throughout, no read strobes, no element skipped or duplicated.
- rst asserted mid-RUN of the third element → next cycle busy=0, z_valid=0, all strobes 0; a new start then yields a correct full result stream.
- K=1, M=N=3, A=all 2, B=all −3 → nine outputs of −6, with 3 cycles per element.
